calc_key_sequencer: RTL and testbench
=====================================

# calc_key_sequencer

Registered, parametrised keypad-entry sequencer for the calculator datapath. It accepts one key code per rising edge of `ready`, assembles multi-digit BCD operands N1 and N2 with an operator between them, and pulses `E` to launch evaluation. It sits between the keypad decoder (`tecla`/`ready`) and the ALU/display stage, and generalises the single-digit combinational entry table into a clocked FSM with configurable operand length, clear and error reporting.

## Interface
- `DIGITS`, default 2: BCD digits per operand, range 1..8.
- `clk` input 1: system clock, all logic on rising edge.
- `reset` input 1: synchronous, active-low reset.
- `tecla` input 4: key code (0-9 digit, A/B/C operator, D equals, E backspace, F clear).
- `ready` input 1: key-valid level from decoder; a key is taken on its rising edge only.
- `N1` output 4*DIGITS: first operand, BCD, least significant digit in [3:0].
- `N2` output 4*DIGITS: second operand, BCD, same packing.
- `OP` output 4: operator code latched (10, 11, 12); 0 = none.
- `state` output 2: current FSM state.
- `E` output 1: execute pulse, one cycle.
- `S` output 1: idle, high in ST_N1 with no digits entered.
- `err` output 1: rejected-key pulse, one cycle.

## Operation
- Key strobe: `ready_q` registers `ready`; accept = `ready & ~ready_q`. `ready_q` resets to 1, so a key held through reset release is not taken.
- Digit counter `cnt`, width $clog2(DIGITS+1), counts digits in the operand being edited.
- States: ST_N1=00, ST_OP=01, ST_N2=10, ST_RE=11.
- ST_N1: digit with cnt<DIGITS -> operand = {operand[4*DIGITS-5:0], key}, cnt+1; digit with cnt==DIGITS -> ignored, err. Operator A/B/C with cnt>0 -> OP=key, cnt=0, go ST_OP; with cnt==0 -> err. D -> err.
- ST_OP: digit -> N2 = key (upper digits 0), cnt=1, go ST_N2. A/B/C -> OP overwritten, stay. D -> err.
- ST_N2: digit rules as ST_N1 applied to N2. D with cnt>0 -> E pulse, go ST_RE. A/B/C -> err.
- ST_RE: N1, N2, OP hold for the ALU. Digit -> clear N1/N2/OP, N1 = key, cnt=1, go ST_N1. D, A/B/C -> ignored, no err.
- F in any state -> N1=N2=0, OP=0, cnt=0, go ST_N1; no err.
- E key: see Configuration.
- Non-accepted cycles: all registers hold; E and err low.

## Timing
- Reset (reset==0 at a rising edge): state=ST_N1, N1=0, N2=0, OP=0, cnt=0, E=0, err=0, S=1, ready_q=1. Reset wins over a simultaneous key.
- Latency: key accepted at edge t -> N1/N2/OP/state/cnt updated and E/err asserted at edge t, visible during cycle t+1; E/err deassert at edge t+1.
- One key per `ready` high period regardless of its length; `ready` must be low ≥1 cycle between keys.
- S is combinational from state and cnt.
- Reset mid-entry discards the partial operand; no E issued.

## Configuration
- `CALC_BACKSPACE_EN` defined: key E in ST_N1/ST_N2 with cnt>0 -> operand shifted right one digit (top digit 0), cnt-1; with cnt==0 in ST_N2 -> N2 cleared, go ST_OP; with cnt==0 in ST_N1 -> err. Key E in ST_OP -> OP=0, cnt=number of significant digits of N1 recomputed as DIGITS-limited stored count, go ST_N1 (N1 count saved in a second counter when leaving ST_N1). Key E in ST_RE ignored.
- Not defined: key E is ignored in every state, no err, no extra counter.

## Test plan
- DIGITS=2: keys 4,2,A,7,D -> N1=0x42, OP=10, N2=0x07, one-cycle E, state=11.
- DIGITS=2: keys 1,2,3 -> N1=0x12, err pulse on third key, state=00, S=0.
- `ready` held high 10 cycles with tecla=5 -> exactly one digit taken, N1=0x05; reset released while ready=1 -> no key taken.
- Keys 3,B,C,9,D -> OP=12; then key 6 in ST_RE -> N1=0x06, N2=0, OP=0, state=00; then F -> all cleared, S=1.
- Keys A from idle and D in ST_OP -> err pulse each, state unchanged; reset asserted in ST_N2 -> all outputs to reset values next cycle.
- With `CALC_BACKSPACE_EN`: keys 8,1,E -> N1=0x08; then A,E -> OP=0, state=00, next digit 2 gives N1=0x82. Without the macro, key E leaves N1=0x81.

Source files
------------

// File: rtl/calc_key_sequencer_if.sv
// -----------------------------------------------------------------------------
// calc_key_sequencer_if
//   Bundles the keypad-side strobe (tecla/ready) and the sequencer results
//   (N1/N2/OP/state/E/S/err) into one connection.
//   Parameter DIGITS : BCD digits per operand (1..8).
//   Modports
//     master : keypad/consumer side, drives tecla/ready and observes results.
//     slave  : sequencer side, observes tecla/ready and drives results.
// -----------------------------------------------------------------------------
interface calc_key_sequencer_if #(
   parameter int DIGITS = 2
);
   logic [3:0]          tecla;
   logic                ready;
   logic [4*DIGITS-1:0] N1;
   logic [4*DIGITS-1:0] N2;
   logic [3:0]          OP;
   logic [1:0]          state;
   logic                E;
   logic                S;
   logic                err;

   modport master (
      output tecla, ready,
      input  N1, N2, OP, state, E, S, err
   );

   modport slave (
      input  tecla, ready,
      output N1, N2, OP, state, E, S, err
   );
endinterface

// File: rtl/calc_key_sequencer.sv
// -----------------------------------------------------------------------------
// calc_key_sequencer
//   Clocked keypad-entry FSM. Takes one key per rising edge of bus.ready,
//   assembles two multi-digit BCD operands with an operator between them and
//   pulses E for one cycle when '=' (D) completes the expression.
//   Ports
//     clk    : system clock, rising edge.
//     reset  : synchronous active-low reset.
//     bus    : calc_key_sequencer_if.slave
//              in  tecla[3:0], ready
//              out N1/N2 [4*DIGITS-1:0], OP[3:0], state[1:0], E, S, err
//   Parameter DIGITS : BCD digits per operand (1..8).
//   Optional feature macro CALC_BACKSPACE_EN : enables key E as backspace.
//   Without it key E is ignored in every state.
// -----------------------------------------------------------------------------
module calc_key_sequencer #(
   parameter int DIGITS = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   calc_key_sequencer_if.slave        bus
);
   localparam int W  = 4 * DIGITS;
   localparam int CW = $clog2(DIGITS + 1);

   localparam logic [3:0] KEY_EQ  = 4'hD;
   localparam logic [3:0] KEY_BS  = 4'hE;
   localparam logic [3:0] KEY_CLR = 4'hF;

   typedef enum logic [1:0] {
      ST_N1 = 2'b00,
      ST_OP = 2'b01,
      ST_N2 = 2'b10,
      ST_RE = 2'b11
   } state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   n1_q, n1_d;
   logic [W-1:0]   n2_q, n2_d;
   logic [3:0]     op_q, op_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           e_q, e_d;
   logic           err_q, err_d;
   logic           ready_q;
`ifdef CALC_BACKSPACE_EN
   // Digit count of N1 remembered when the operator is entered, so that
   // backspacing out of ST_OP resumes editing N1 where it left off.
   logic [CW-1:0]  cnt1_q, cnt1_d;
`endif

   logic accept;
   logic is_digit;
   logic is_op;
   logic cnt_full;
   logic cnt_zero;

   // Rising-edge detect; ready_q resets high so a key held across reset
   // release is not taken.
   assign accept   = bus.ready & ~ready_q;
   assign is_digit = (bus.tecla <= 4'd9);
   assign is_op    = (bus.tecla >= 4'hA) && (bus.tecla <= 4'hC);
   assign cnt_full = (cnt_q == CW'(DIGITS));
   assign cnt_zero = (cnt_q == '0);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_N1;
         n1_q    <= '0;
         n2_q    <= '0;
         op_q    <= '0;
         cnt_q   <= '0;
         e_q     <= 1'b0;
         err_q   <= 1'b0;
         ready_q <= 1'b1;
`ifdef CALC_BACKSPACE_EN
         cnt1_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         n1_q    <= n1_d;
         n2_q    <= n2_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         e_q     <= e_d;
         err_q   <= err_d;
         ready_q <= bus.ready;
`ifdef CALC_BACKSPACE_EN
         cnt1_q  <= cnt1_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      n1_d    = n1_q;
      n2_d    = n2_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      e_d     = 1'b0;
      err_d   = 1'b0;
`ifdef CALC_BACKSPACE_EN
      cnt1_d  = cnt1_q;
`endif
      if (accept) begin
         if (bus.tecla == KEY_CLR) begin
            n1_d    = '0;
            n2_d    = '0;
            op_d    = '0;
            cnt_d   = '0;
            state_d = ST_N1;
         end else begin
            case (state_q)
               ST_N1: begin
                  if (is_digit) begin
                     if (!cnt_full) begin
                        // Shift left one digit; new key enters at the LSD.
                        n1_d  = (n1_q << 4) | W'(bus.tecla);
                        cnt_d = cnt_q + CW'(1);
                     end else begin
                        err_d = 1'b1;
                     end
                  end else if (is_op) begin
                     if (!cnt_zero) begin
                        op_d    = bus.tecla;
                        cnt_d   = '0;
                        state_d = ST_OP;
`ifdef CALC_BACKSPACE_EN
                        cnt1_d  = cnt_q;
`endif
                     end else begin
                        err_d = 1'b1;
                     end
                  end else if (bus.tecla == KEY_EQ) begin
                     err_d = 1'b1;
                  end else if (bus.tecla == KEY_BS) begin
`ifdef CALC_BACKSPACE_EN
                     if (!cnt_zero) begin
                        n1_d  = n1_q >> 4;
                        cnt_d = cnt_q - CW'(1);
                     end else begin
                        err_d = 1'b1;
                     end
`endif
                  end
               end
               ST_OP: begin
                  if (is_digit) begin
                     n2_d    = W'(bus.tecla);
                     cnt_d   = CW'(1);
                     state_d = ST_N2;
                  end else if (is_op) begin
                     op_d = bus.tecla;
                  end else if (bus.tecla == KEY_EQ) begin
                     err_d = 1'b1;
                  end else if (bus.tecla == KEY_BS) begin
`ifdef CALC_BACKSPACE_EN
                     op_d    = '0;
                     cnt_d   = cnt1_q;
                     state_d = ST_N1;
`endif
                  end
               end
               ST_N2: begin
                  if (is_digit) begin
                     if (!cnt_full) begin
                        n2_d  = (n2_q << 4) | W'(bus.tecla);
                        cnt_d = cnt_q + CW'(1);
                     end else begin
                        err_d = 1'b1;
                     end
                  end else if (bus.tecla == KEY_EQ) begin
                     // An empty N2 (only reachable by backspacing) cannot
                     // be evaluated.
                     if (!cnt_zero) begin
                        e_d     = 1'b1;
                        state_d = ST_RE;
                     end else begin
                        err_d = 1'b1;
                     end
                  end else if (is_op) begin
                     err_d = 1'b1;
                  end else if (bus.tecla == KEY_BS) begin
`ifdef CALC_BACKSPACE_EN
                     if (!cnt_zero) begin
                        n2_d  = n2_q >> 4;
                        cnt_d = cnt_q - CW'(1);
                     end else begin
                        n2_d    = '0;
                        state_d = ST_OP;
                     end
`endif
                  end
               end
               ST_RE: begin
                  // Result is held for the ALU; only a digit starts a new
                  // expression, everything else is silently ignored.
                  if (is_digit) begin
                     n1_d    = W'(bus.tecla);
                     n2_d    = '0;
                     op_d    = '0;
                     cnt_d   = CW'(1);
                     state_d = ST_N1;
                  end
               end
               default: state_d = ST_N1;
            endcase
         end
      end
   end

   assign bus.N1    = n1_q;
   assign bus.N2    = n2_q;
   assign bus.OP    = op_q;
   assign bus.state = state_q;
   assign bus.E     = e_q;
   assign bus.err   = err_q;
   assign bus.S     = (state_q == ST_N1) && cnt_zero;

endmodule

// File: tb/tb_calc_key_sequencer.sv
// -----------------------------------------------------------------------------
// tb_calc_key_sequencer
//   Directed bench for calc_key_sequencer with DIGITS=2. Keys are pressed one
//   at a time with hand-computed expectations checked after each step.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_calc_key_sequencer;
   logic clk;
   logic reset;

   int total_cnt;
   int pass_cnt;

   logic e_now, err_now, e_next, err_next;

   calc_key_sequencer_if #(.DIGITS(2)) bus ();

   calc_key_sequencer #(.DIGITS(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Present one key for a single ready-high cycle. Flags sampled just after
   // the accepting edge and again one cycle later.
   task automatic press(input logic [3:0] k);
      @(negedge clk);
      bus.tecla = k;
      bus.ready = 1'b1;
      @(posedge clk);
      #1;
      e_now   = bus.E;
      err_now = bus.err;
      @(negedge clk);
      bus.ready = 1'b0;
      @(posedge clk);
      #1;
      e_next   = bus.E;
      err_next = bus.err;
      $display("key %h -> N1=%h N2=%h OP=%0d state=%0d E=%b err=%b S=%b",
               k, bus.N1, bus.N2, bus.OP, bus.state, e_now, err_now, bus.S);
   endtask

   initial begin
      total_cnt = 0;
      pass_cnt  = 0;
      reset     = 1'b0;
      bus.ready = 1'b1;
      bus.tecla = 4'h5;

      // Reset held with a key already pressed
      repeat (3) @(posedge clk);
      #1;
      check("rst_state", 32'(bus.state), 32'd0);
      check("rst_N1",    32'(bus.N1),    32'h0);
      check("rst_N2",    32'(bus.N2),    32'h0);
      check("rst_OP",    32'(bus.OP),    32'd0);
      check("rst_E",     32'(bus.E),     32'd0);
      check("rst_err",   32'(bus.err),   32'd0);
      check("rst_S",     32'(bus.S),     32'd1);
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("held_thru_rst_N1", 32'(bus.N1), 32'h0);
      check("held_thru_rst_S",  32'(bus.S),  32'd1);
      @(negedge clk);
      bus.ready = 1'b0;
      @(posedge clk);

      // 4 2 A 7 D
      press(4'h4);
      check("n1_first", 32'(bus.N1), 32'h04);
      check("S_busy",   32'(bus.S),  32'd0);
      press(4'h2);
      check("n1_42", 32'(bus.N1), 32'h42);
      press(4'hA);
      check("op_A",     32'(bus.OP),    32'd10);
      check("st_op",    32'(bus.state), 32'd1);
      press(4'h7);
      check("n2_07",    32'(bus.N2),    32'h07);
      check("st_n2",    32'(bus.state), 32'd2);
      press(4'hD);
      check("E_pulse",  32'(e_now),     32'd1);
      check("E_drop",   32'(e_next),    32'd0);
      check("st_re",    32'(bus.state), 32'd3);
      check("re_N1",    32'(bus.N1),    32'h42);

      // New digit in ST_RE starts over, then clear
      press(4'h6);
      check("re_dig_N1", 32'(bus.N1),    32'h06);
      check("re_dig_N2", 32'(bus.N2),    32'h00);
      check("re_dig_OP", 32'(bus.OP),    32'd0);
      check("re_dig_st", 32'(bus.state), 32'd0);
      press(4'hF);
      check("clr_N1", 32'(bus.N1), 32'h0);
      check("clr_S",  32'(bus.S),  32'd1);

      // Operand overflow: 1 2 3
      press(4'h1);
      press(4'h2);
      check("ovf_no_err", 32'(err_now), 32'd0);
      press(4'h3);
      check("ovf_err",      32'(err_now),   32'd1);
      check("ovf_err_drop", 32'(err_next),  32'd0);
      check("ovf_N1",       32'(bus.N1),    32'h12);
      check("ovf_st",       32'(bus.state), 32'd0);
      check("ovf_S",        32'(bus.S),     32'd0);
      press(4'hF);

      // ready held high 10 cycles -> one key only
      @(negedge clk);
      bus.tecla = 4'h5;
      bus.ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("hold_N1", 32'(bus.N1), 32'h05);
      @(negedge clk);
      bus.ready = 1'b0;
      @(posedge clk);
      #1;
      check("hold_N1_after", 32'(bus.N1), 32'h05);
      press(4'hF);

      // Error keys and OP overwrite
      press(4'hA);
      check("idle_op_err", 32'(err_now),   32'd1);
      check("idle_op_st",  32'(bus.state), 32'd0);
      press(4'h3);
      press(4'hB);
      press(4'hC);
      check("op_overwrite", 32'(bus.OP),    32'd12);
      check("op_ow_noerr",  32'(err_now),   32'd0);
      press(4'hD);
      check("op_D_err",     32'(err_now),   32'd1);
      check("op_D_st",      32'(bus.state), 32'd1);
      press(4'h9);
      press(4'hD);
      check("eq2_E",  32'(e_now),     32'd1);
      check("eq2_st", 32'(bus.state), 32'd3);
      check("eq2_N1", 32'(bus.N1),    32'h03);
      check("eq2_N2", 32'(bus.N2),    32'h09);
      check("eq2_OP", 32'(bus.OP),    32'd12);
      press(4'hD);
      check("re_D_ignored", 32'(err_now | e_now), 32'd0);
      press(4'hF);
      check("clr2_OP", 32'(bus.OP), 32'd0);
      check("clr2_S",  32'(bus.S),  32'd1);

      // Reset mid-entry in ST_N2
      press(4'h1);
      press(4'hA);
      press(4'h2);
      check("pre_rst_st", 32'(bus.state), 32'd2);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("mid_rst_st", 32'(bus.state), 32'd0);
      check("mid_rst_N1", 32'(bus.N1),    32'h0);
      check("mid_rst_N2", 32'(bus.N2),    32'h0);
      check("mid_rst_OP", 32'(bus.OP),    32'd0);
      check("mid_rst_S",  32'(bus.S),     32'd1);
      check("mid_rst_E",  32'(bus.E),     32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);

      // Key E: backspace when enabled, ignored otherwise
      press(4'h8);
      press(4'h1);
      press(4'hE);
      check("bs_noerr", 32'(err_now), 32'd0);
`ifdef CALC_BACKSPACE_EN
      check("bs_N1", 32'(bus.N1), 32'h08);
      press(4'hA);
      press(4'hE);
      check("bs_op_OP", 32'(bus.OP),    32'd0);
      check("bs_op_st", 32'(bus.state), 32'd0);
      press(4'h2);
      check("bs_resume_N1", 32'(bus.N1), 32'h82);
`else
      check("bs_off_N1", 32'(bus.N1), 32'h81);
      press(4'hA);
      press(4'hE);
      check("bs_off_OP", 32'(bus.OP),    32'd10);
      check("bs_off_st", 32'(bus.state), 32'd1);
      check("bs_off_err", 32'(err_now),  32'd0);
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
